map_rom_arbiter: RTL and testbench

- Shares the single-port map_rom (obstacle rectangle table) between several map walkers: the pacman mover and one collision-scan datapath per ghost.
- Each walker drives a request and an address. The arbiter grants one walker per cycle, steers its address to the ROM, and returns the ROM word tagged with a one-hot valid.
- Optional lock lets a walker hold the ROM for an uninterrupted rectangle scan. Lock hold is bounded by a starvation timeout.

---
 rtl/map_pkg.sv | 17 +
 rtl/map_rom_arbiter_if.sv | 28 ++
 rtl/rr_pick.sv | 30 +++
 rtl/map_rom_arbiter.sv | 133 +++++++++++++
 tb/tb_map_rom_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/map_pkg.sv
// Shared map ROM types and sizes for the map walkers and the ROM arbiter.
package map_pkg;

  localparam int unsigned RECT_W     = 38;
  localparam int unsigned NUM_RECTS  = 21;
  localparam int unsigned MAP_ADDR_W = 5;

  typedef struct packed {
    logic [9:0] x0;
    logic [8:0] y0;
    logic [9:0] x1;
    logic [8:0] y1;
  } rect_t;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

endpackage

// File: rtl/map_rom_arbiter_if.sv
// Walker-side bus of the map ROM arbiter: requests in, grants and returned words out.
interface map_rom_arbiter_if
  import map_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = MAP_ADDR_W,
  parameter int unsigned DATA_W = RECT_W
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;
  logic [N_REQ-1:0]        lock_owner;

  modport master (
    output req, lock, addr,
    input  gnt, rvalid, rdata, lock_owner
  );

  modport slave (
    input  req, lock, addr,
    output gnt, rvalid, rdata, lock_owner
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int unsigned k;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = 32'(ptr) + i;
      if (k >= N) k = k - N;
      if (!valid && req[k[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = k[IDX_W-1:0];
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/map_rom_arbiter.sv
// Shares the single-port map ROM between walkers: round-robin grant, optional
// bounded lock for uninterrupted rectangle scans, one-cycle tagged return path.
module map_rom_arbiter
  import map_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned ADDR_W    = MAP_ADDR_W,
  parameter int unsigned DATA_W    = RECT_W,
  parameter int unsigned NUM_RECTS = map_pkg::NUM_RECTS,
  parameter int unsigned MAX_LOCK  = 32
) (
  input  logic                clk,
  input  logic                reset,
  map_rom_arbiter_if.slave    bus,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_q
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] MaxCnt  = CNT_W'(MAX_LOCK);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   inhibit_q, inhibit_d;
  logic               rv_q, rv_d;
  logic [IDX_W-1:0]   rv_idx_q, rv_idx_d;
  logic               rv_in_range_q, rv_in_range_d;

  logic [ADDR_W-1:0]  addr_arr [N_REQ];
  logic [N_REQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  logic               hold;
  logic [N_REQ-1:0]   inh_eff;
  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic [N_REQ-1:0]   win_gnt;
  logic [ADDR_W-1:0]  win_addr;

  for (genvar k = 0; k < N_REQ; k++) begin : g_addr
    assign addr_arr[k] = bus.addr[k*ADDR_W +: ADDR_W];
  end

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    hold = (state_q == LOCKED) && bus.req[owner_q] && bus.lock[owner_q] && (cnt_q != MaxCnt);
    // A timed-out owner is barred from re-locking in the very cycle it is released.
    inh_eff = inhibit_q;
    if ((state_q == LOCKED) && (cnt_q == MaxCnt)) inh_eff[owner_q] = 1'b1;

    state_d   = IDLE;
    owner_d   = owner_q;
    cnt_d     = '0;
    win_valid = 1'b0;
    win_idx   = '0;
    win_gnt   = '0;
    if (hold) begin
      state_d          = LOCKED;
      cnt_d            = cnt_q + 1'b1;
      win_valid        = 1'b1;
      win_idx          = owner_q;
      win_gnt[owner_q] = 1'b1;
    end else begin
      win_valid = pick_valid;
      win_idx   = pick_idx;
      win_gnt   = pick_gnt;
      if (pick_valid && bus.lock[pick_idx] && !inh_eff[pick_idx]) begin
        state_d = LOCKED;
        owner_d = pick_idx;
        cnt_d   = CNT_W'(1);
      end
    end

    inhibit_d = inh_eff & bus.lock;

    ptr_d = ptr_q;
    if (win_valid) ptr_d = (win_idx == LastIdx) ? '0 : win_idx + 1'b1;

    win_addr      = addr_arr[win_idx];
    rv_d          = win_valid;
    rv_idx_d      = win_idx;
    rv_in_range_d = {{(32 - ADDR_W){1'b0}}, win_addr} < NUM_RECTS;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      inhibit_q     <= '0;
      rv_q          <= 1'b0;
      rv_idx_q      <= '0;
      rv_in_range_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      inhibit_q     <= inhibit_d;
      rv_q          <= rv_d;
      rv_idx_q      <= rv_idx_d;
      rv_in_range_q <= rv_in_range_d;
    end
  end

  // Outputs are gated by reset so a read in flight when reset hits never returns.
  always_comb begin
    bus.gnt        = (reset && win_valid) ? win_gnt : '0;
    rom_addr       = (reset && win_valid) ? win_addr : '0;
    bus.rvalid     = '0;
    bus.lock_owner = '0;
    if (reset && rv_q) bus.rvalid[rv_idx_q] = 1'b1;
    if (reset && (state_q == LOCKED)) bus.lock_owner[owner_q] = 1'b1;
    bus.rdata = (reset && rv_q && rv_in_range_q) ? rom_q : '0;
  end

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Randomised scoreboard bench for map_rom_arbiter with a behavioural arbitration model.
module tb_map_rom_arbiter;
  import map_pkg::*;

  localparam int N        = 4;
  localparam int MAX_LOCK = 32;
  localparam int NRECT    = 21;

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] lo;
    logic [4:0] ra;
  } cyc_t;

  typedef struct {
    int          due;
    int          idx;
    logic [37:0] data;
  } ret_t;

  logic        clk;
  logic        reset;
  logic [4:0]  rom_addr;
  logic [37:0] rom_q;
  logic [37:0] rom_mem [32];

  cyc_t exp_cyc[$];
  ret_t exp_ret[$];
  int   cyc;
  int   checks;
  int   errors;

  // Reference model state
  int       m_ptr;
  int       m_owner;
  int       m_held;
  bit       m_locked;
  bit [3:0] m_inh;

  map_rom_arbiter_if #(.N_REQ(4), .ADDR_W(5), .DATA_W(38)) bus ();

  map_rom_arbiter #(
    .N_REQ     (4),
    .ADDR_W    (5),
    .DATA_W    (38),
    .NUM_RECTS (21),
    .MAX_LOCK  (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_q    (rom_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  function automatic logic [19:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  // One cycle of stimulus plus the expected response it implies.
  task automatic drive(input logic rst, input logic [3:0] r, input logic [3:0] l,
                       input logic [19:0] a, output int win);
    cyc_t     e;
    ret_t     rt;
    bit [3:0] eff;
    int       k;
    int       wa;
    @(posedge clk);
    #2;
    reset    = rst;
    bus.req  = r;
    bus.lock = l;
    bus.addr = a;
    cyc++;
    win  = -1;
    e.gnt = '0;
    e.ra  = '0;
    e.lo  = m_locked ? 4'(1 << m_owner) : 4'b0;
    if (!rst) begin
      m_ptr = 0; m_locked = 0; m_held = 0; m_inh = '0; m_owner = 0;
      e.lo = '0;
      exp_ret.delete();
    end else begin
      eff = m_inh;
      if (m_locked && r[m_owner] && l[m_owner] && m_held < MAX_LOCK) begin
        win = m_owner;
        m_held++;
      end else begin
        if (m_locked && m_held == MAX_LOCK) eff[m_owner] = 1'b1;
        m_locked = 0;
        for (int i = 0; i < N; i++) begin
          k = (m_ptr + i) % N;
          if (win < 0 && r[k]) win = k;
        end
        if (win >= 0 && l[win] && !eff[win]) begin
          m_locked = 1; m_owner = win; m_held = 1;
        end
      end
      m_inh = eff & l;
      if (win >= 0) begin
        m_ptr = (win + 1) % N;
        wa = int'(a[win*5 +: 5]);
        e.gnt = 4'(1 << win);
        e.ra  = 5'(wa);
        rt.due  = cyc + 1;
        rt.idx  = win;
        rt.data = (wa < NRECT) ? rom_mem[wa] : 38'b0;
        exp_ret.push_back(rt);
      end
    end
    exp_cyc.push_back(e);
  endtask

  // Monitor: compares DUT outputs against the queued expectations each cycle.
  initial begin
    cyc_t e;
    ret_t rt;
    forever begin
      @(negedge clk);
      if (cyc > 0 && exp_cyc.size() > 0) begin
        e = exp_cyc.pop_front();
        checks++;
        if (bus.gnt !== e.gnt || rom_addr !== e.ra) begin
          errors++;
          $display("FAIL grant c%0d: got gnt=%b rom_addr=%0d, expected gnt=%b rom_addr=%0d",
                   cyc, bus.gnt, rom_addr, e.gnt, e.ra);
        end
        checks++;
        if (bus.lock_owner !== e.lo) begin
          errors++;
          $display("FAIL lock_owner c%0d: got %b expected %b", cyc, bus.lock_owner, e.lo);
        end
        checks++;
        if (bus.rvalid !== 4'b0) begin
          if (exp_ret.size() == 0) begin
            errors++;
            $display("FAIL rvalid c%0d: got %b expected 0000", cyc, bus.rvalid);
          end else begin
            rt = exp_ret.pop_front();
            if (rt.due != cyc || bus.rvalid !== 4'(1 << rt.idx) || bus.rdata !== rt.data) begin
              errors++;
              $display("FAIL return c%0d: got rvalid=%b rdata=%h, expected rvalid=%b rdata=%h due c%0d",
                       cyc, bus.rvalid, bus.rdata, 4'(1 << rt.idx), rt.data, rt.due);
            end
          end
        end else begin
          if (bus.rdata !== 38'b0) begin
            errors++;
            $display("FAIL idle rdata c%0d: got %h expected 0", cyc, bus.rdata);
          end else if (exp_ret.size() > 0 && exp_ret[0].due <= cyc) begin
            rt = exp_ret.pop_front();
            errors++;
            $display("FAIL missing rvalid c%0d: got 0000 expected %b", cyc, 4'(1 << rt.idx));
          end
        end
      end
    end
  end

  initial begin
    int         w;
    int         sw;
    logic [3:0] rl;
    logic [3:0] rr;
    cyc = 0; checks = 0; errors = 0;
    m_ptr = 0; m_owner = 0; m_held = 0; m_locked = 0; m_inh = '0;
    for (int i = 0; i < 32; i++) rom_mem[i] = 38'({$urandom(), $urandom()}) | 38'h1;
    reset = 1'b0; bus.req = '0; bus.lock = '0; bus.addr = '0;

    // Reset held with all requesting, then plain round robin on addr k+3.
    for (int i = 0; i < 3; i++) drive(1'b0, 4'b1111, 4'b0000, pk(3, 4, 5, 6), w);
    for (int i = 0; i < 6; i++) drive(1'b1, 4'b1111, 4'b0000, pk(3, 4, 5, 6), w);

    // Locked sweep by requester 2 while 0 and 1 keep requesting.
    sw = 0;
    for (int i = 0; i < 80 && sw < NRECT; i++) begin
      drive(1'b1, 4'b0111, 4'b0100, pk(1, 2, sw, 0), w);
      if (w == 2) sw++;
    end
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b0111, 4'b0000, pk(1, 2, 0, 0), w);
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b1111, 4'b0000, pk(1, 2, 7, 8), w);

    // Lock timeout: requester 1 holds lock for 40 cycles, then toggles it to re-lock.
    drive(1'b0, 4'b0000, 4'b0000, '0, w);
    for (int i = 0; i < 40; i++) drive(1'b1, 4'b0011, 4'b0010, pk(9, i % 32, 0, 0), w);
    drive(1'b1, 4'b0011, 4'b0000, pk(9, 10, 0, 0), w);
    for (int i = 0; i < 6; i++) drive(1'b1, 4'b0011, 4'b0010, pk(9, 11, 0, 0), w);
    drive(1'b1, 4'b0000, 4'b0000, '0, w);

    // Out-of-range reads by requester 3.
    drive(1'b1, 4'b1000, 4'b0000, pk(0, 0, 0, 21), w);
    drive(1'b1, 4'b1000, 4'b0000, pk(0, 0, 0, 31), w);
    drive(1'b1, 4'b1000, 4'b0000, pk(0, 0, 0, 20), w);
    drive(1'b1, 4'b1000, 4'b0000, pk(0, 0, 0, 0), w);

    // Reset while a read is in flight.
    drive(1'b1, 4'b0010, 4'b0000, pk(0, 5, 0, 0), w);
    drive(1'b0, 4'b1111, 4'b0000, pk(0, 5, 0, 0), w);
    drive(1'b1, 4'b1111, 4'b0000, pk(2, 5, 6, 7), w);

    // Random traffic with sticky lock bits and rare resets.
    rl = '0;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++) begin
        rr[k] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) rl[k] = ~rl[k];
      end
      drive(($urandom_range(0, 99) != 0), rr, rl, 20'($urandom()), w);
    end

    for (int i = 0; i < 3; i++) drive(1'b1, 4'b0000, 4'b0000, '0, w);
    @(negedge clk);
    #1;
    checks++;
    if (exp_ret.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d returns outstanding, expected 0", exp_ret.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
